// File: rtl/anubis_pkg.sv
// anubis_pkg: shared widths, round counts and controller state type for the ANUBIS sequencer
package anubis_pkg;
    localparam int BLOCK_W       = 128;
    localparam int ANUBIS_ROUNDS = 12;
    localparam int PHASES_FULL   = 4;
    localparam int PHASES_LAST   = 3;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_CAPTURE, ST_DONE} ctrl_state_e;
endpackage

// File: rtl/anubis_round_ctrl_if.sv
// anubis_round_ctrl_if: block handshake, key-store lookup and round-datapath signals of the sequencer
interface anubis_round_ctrl_if;
    import anubis_pkg::*;
    logic               start;
    logic [BLOCK_W-1:0] plain_text;
    logic               ready;
    logic [3:0]         key_idx;
    logic [BLOCK_W-1:0] key_in;
    logic               load_text;
    logic               clk_en;
    logic [3:0]         round_number;
    logic [BLOCK_W-1:0] round_plain_text;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_cipher_text;
    logic [BLOCK_W-1:0] cipher_text;
    logic               done;
    modport master (
        output start, plain_text, key_in, round_cipher_text,
        input  ready, key_idx, load_text, clk_en, round_number, round_plain_text, round_key, cipher_text, done
    );
    modport slave (
        input  start, plain_text, key_in, round_cipher_text,
        output ready, key_idx, load_text, clk_en, round_number, round_plain_text, round_key, cipher_text, done
    );
endinterface

// File: rtl/anubis_en_div.sv
// anubis_en_div: EN_PERIOD clock divider with synchronous clear and a registered one-cycle strobe
module anubis_en_div #(
    parameter int EN_PERIOD = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic strobe
);
    localparam int W = $clog2(EN_PERIOD);
    logic [W-1:0] cnt;
    // strobe is set one count early so it is itself a flop, high exactly while cnt == EN_PERIOD-1
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            cnt    <= !en ? cnt : strobe ? '0 : cnt + 1'b1;
            strobe <= en && cnt == W'(EN_PERIOD - 2);
        end
    end
endmodule

// File: rtl/anubis_round_ctrl.sv
// anubis_round_ctrl: sequences whitening and the 12 ANUBIS rounds through the external round datapath
module anubis_round_ctrl
    import anubis_pkg::*;
#(
    parameter int EN_PERIOD = 3
) (
    input  logic                clk,
    input  logic                reset,
    anubis_round_ctrl_if.slave  bus
);
    localparam logic [3:0] LAST_RND = 4'(ANUBIS_ROUNDS);
    ctrl_state_e        state, state_nx;
    logic [3:0]         round;
    logic [2:0]         pulses;
    logic [2:0]         need_m1;
    logic [BLOCK_W-1:0] data_reg;
    logic [BLOCK_W-1:0] cipher;
    logic               load_q, done_q, strobe, last_phase;

    anubis_en_div #(.EN_PERIOD(EN_PERIOD)) u_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_LOAD),
        .en     (state == ST_RUN),
        .strobe (strobe)
    );

    // the last round skips the final sigma phase, so it needs one strobe fewer
    assign need_m1    = (round == LAST_RND) ? 3'(PHASES_LAST - 1) : 3'(PHASES_FULL - 1);
    assign last_phase = strobe && pulses == need_m1;

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:    state_nx = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD:    state_nx = ST_RUN;
            ST_RUN:     state_nx = last_phase ? ST_CAPTURE : ST_RUN;
            ST_CAPTURE: state_nx = (round == LAST_RND) ? ST_DONE : ST_LOAD;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            round    <= '0;
            pulses   <= '0;
            data_reg <= '0;
            cipher   <= '0;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            load_q <= state_nx == ST_LOAD;
            done_q <= state_nx == ST_DONE;
            if (state == ST_LOAD)
                pulses <= '0;
            else if (state == ST_RUN && strobe)
                pulses <= pulses + 3'd1;
            if (state == ST_IDLE && bus.start) begin
                data_reg <= bus.plain_text ^ bus.key_in;
                round    <= 4'd1;
            end
            if (state == ST_CAPTURE) begin
                data_reg <= bus.round_cipher_text;
                if (round == LAST_RND)
                    cipher <= bus.round_cipher_text;
                else
                    round <= round + 4'd1;
            end
        end
    end

    assign bus.ready            = state == ST_IDLE;
    assign bus.key_idx          = bus.ready ? 4'd0 : round;
    assign bus.round_number     = bus.ready ? 4'd0 : round;
    assign bus.load_text        = load_q;
    assign bus.clk_en           = strobe;
    assign bus.round_plain_text = data_reg;
    assign bus.round_key        = bus.key_in;
    assign bus.cipher_text      = cipher;
    assign bus.done             = done_q;
endmodule

// File: doc/anubis_round_ctrl.md
# anubis_round_ctrl

Sequencer that drives the ANUBIS `round` datapath for 128-bit blocks under a 128-bit key (12 rounds). It accepts a plaintext with a start strobe and applies initial key whitening with key 0. It then runs rounds 1..12 through `round`, generating `load_text`, the `clk_en` strobe, `round_number` and round-key selection, and feeds each round's output back as the next round's input. It sits directly upstream of `round` and downstream of the key-schedule store, which is indexed by `key_idx`.

## Interface
Parameters:
- EN_PERIOD, 3: clock cycles per `clk_en` strobe; legal range ≥ 3, since theta needs 3 cycles for its ROM access.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin encryption of `plain_text`; sampled only when `ready`=1
- plain_text  in  128  input block; sampled with `start`
- ready  out  1  high in IDLE only
- key_idx  out  4  round-key index to key store; 0 in IDLE, current round otherwise
- key_in  in  128  round key for `key_idx`; combinational lookup, valid in the same cycle
- load_text  out  1  to `round`; one-cycle pulse at the start of each round
- clk_en  out  1  to `round`; one-cycle strobe every EN_PERIOD cycles in RUN
- round_number  out  4  to `round`; current round, 1..12; 0 in IDLE
- round_plain_text  out  128  to `round`; the state register
- round_key  out  128  to `round`; equal to `key_in` (pass-through)
- round_cipher_text  in  128  from `round`
- cipher_text  out  128  final ciphertext; held until the next completion
- done  out  1  one-cycle pulse when `cipher_text` updates

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, DONE.
- IDLE:
  - `ready`=1, `key_idx`=0.
  - On `start`: `data_reg` ← `plain_text` ^ `key_in`, `round` ← 1, go to LOAD.
- LOAD:
  - `load_text`=1 for one cycle.
  - Divider and pulse counter cleared.
  - Go to RUN.
- RUN:
  - Divider counts 0..EN_PERIOD-1.
  - `clk_en`=1 when divider = EN_PERIOD-1.
  - Pulse counter increments on each strobe.
  - After strobe number NEED go to CAPTURE. NEED=4 for rounds 1..11 (gamma, tau, theta, sigma); NEED=3 for round 12.
- CAPTURE:
  - `data_reg` ← `round_cipher_text`.
  - If `round`=12: `cipher_text` ← `round_cipher_text`, go to DONE.
  - Otherwise `round`++, go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `round_plain_text` = `data_reg`; stable for the entire round.
- `round_number` = `round` in LOAD/RUN/CAPTURE.
- `start` outside IDLE is ignored; no queuing.
- Reset (also mid-run): state IDLE, `round`=0, counters 0, `data_reg`=0, `cipher_text`=0, `done`/`load_text`/`clk_en`=0, `ready`=1. `round` shares the same reset.

## Timing
- `load_text` and `clk_en` come from posedge flops; `round` samples them at the following negedge.
- Per round: 1 (LOAD) + NEED·EN_PERIOD (RUN) + 1 (CAPTURE) cycles. With EN_PERIOD=3: 14 cycles for rounds 1..11, 11 cycles for round 12.
- Latency from the `start`-sampling edge to the `done` cycle: 47·EN_PERIOD + 25 cycles; 166 for EN_PERIOD=3.
- `cipher_text` is valid in the `done` cycle.
- `ready` is high again in the cycle after `done`.
- Back-to-back: `start` in that cycle is accepted.

## Structure
- Shared package `anubis_pkg`:
  - BLOCK_W=128
  - ANUBIS_ROUNDS=12
  - PHASES_FULL=4, PHASES_LAST=3
  - ctrl state enum
- Sub-module `anubis_en_div`: EN_PERIOD divider with synchronous clear and strobe output; the controller instantiates one.
- This controller instantiates neither `round` nor the key store. The top level wires them.

## Test plan
- Reset, then idle 10 cycles → `ready`=1, `cipher_text`=0, `load_text`/`clk_en`/`done` never high.
- `plain_text`=128'h0123…CDEF, `key_in`=128'h1 when `key_idx`=0, `start` → first LOAD shows `round_plain_text`=128'h0123…CDEE, `round_number`=1, `key_idx`=1.
- Full run with a stub `round` that returns `round_plain_text`+`round_number`:
  - exactly 47 `clk_en` strobes and 12 `load_text` pulses
  - `done` exactly 166 cycles after `start`
  - `cipher_text` = whitened input + 78
- Strobe spacing: `clk_en` gaps are exactly 3 cycles inside each round; 4 strobes in rounds 1..11, 3 in round 12. With EN_PERIOD=5, latency is 260.
- `start` pulsed during RUN → ignored, no effect on `data_reg`. `start` held through the `done` cycle → second encryption begins on the next cycle.
- `reset` asserted during round 6, RUN → next cycle IDLE, all outputs at reset values. A new `start` completes correctly in 166 cycles.
